// File: rtl/prio_encode_drain_pkg.sv
// Shared types and width helper for the priority-encode-and-drain block.
// Build option ENC_MSB_FIRST_EN (see prio_find) flips the drain order to descending.
package enc_pkg;

    typedef enum logic {IDLE, DRAIN} enc_state_t;

    // Index width for an n-bit request vector.
    function automatic int enc_idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encode_drain_if.sv
// Load/drain handshake bundle: the master loads request vectors and consumes indices,
// the slave (the encoder) accepts loads and produces one index per beat.
interface prio_encode_drain_if
    import enc_pkg::*;
#(
    parameter int N = 4
);
    localparam int W = enc_idx_width(N);

    logic [N-1:0] x;
    logic         en;
    logic         in_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         last;
    logic         busy;

    modport master (
        output x, en, y_ready,
        input  in_ready, y, y_valid, last, busy
    );

    modport slave (
        input  x, en, y_ready,
        output in_ready, y, y_valid, last, busy
    );

endinterface

// File: rtl/prio_encode_drain_find.sv
// Combinational priority search over a request vector.
// ENC_MSB_FIRST_EN selects the highest set bit; otherwise the lowest set bit wins.
module prio_find
    import enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = enc_idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         onehot
);

    always_comb begin
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        // Ascending scan: the final hit is the highest set bit.
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx = W'(i);
        end
`else
        // Descending scan: the final hit is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
`endif
    end

    assign any    = |req;
    assign onehot = any && ((req & (req - N'(1))) == '0);

endmodule

// File: rtl/prio_encode_drain.sv
// Captures a request vector and drains the index of each set bit, one per accepted beat.
// ENC_MSB_FIRST_EN (in prio_find) selects descending drain order.
module prio_encode_drain
    import enc_pkg::*;
#(
    parameter int N = 4,
    localparam int W = enc_idx_width(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_encode_drain_if.slave    bus
);

    enc_state_t   state_reg;
    logic [N-1:0] pending_reg;

    logic [W-1:0] find_idx;
    logic         find_any;
    logic         find_onehot;
    logic         draining;
    logic         beat;
    logic [N-1:0] clear_mask;

    prio_find #(.N(N)) u_find (
        .req    (pending_reg),
        .idx    (find_idx),
        .any    (find_any),
        .onehot (find_onehot)
    );

    assign draining   = (state_reg == DRAIN);
    assign beat       = draining && bus.y_ready;
    assign clear_mask = ~(N'(1) << find_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.en && (bus.x != '0)) begin
                        pending_reg <= bus.x;
                        state_reg   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        pending_reg <= pending_reg & clear_mask;
                        if (find_onehot) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state only; y and last read zero outside DRAIN.
    assign bus.in_ready = (state_reg == IDLE);
    assign bus.y_valid  = draining && find_any;
    assign bus.busy     = draining;
    assign bus.y        = draining ? find_idx : '0;
    assign bus.last     = draining && find_onehot;

endmodule
